// File: rtl/regfile_32x64.sv
`timescale 1ns/1ps
// regfile_32x64: 32x64 register file, two combinational read ports, hardwired-zero reg 31, sequenced clear engine
module regfile_32x64 #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RegWrite,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2,
  input  logic             clear_req,
  output logic             busy,
  output logic             clear_done
);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  localparam logic [4:0] LAST = 5'(DEPTH - 2);
  state_t           r_state, w_state_nxt;
  logic [4:0]       r_cnt, w_cnt_nxt;
  logic             w_block;
  logic [DEPTH-1:0] w_wen, w_cen;
  logic [WIDTH-1:0] w_regs [DEPTH];
  // a clear request in IDLE already claims the write port for that cycle
  assign w_block    = busy | (r_state == IDLE && clear_req);
  assign w_wen      = (RegWrite && !w_block) ? (DEPTH'(1) << WriteRegister) : '0;
  assign w_cen      = (r_state == CLEAR) ? (DEPTH'(1) << r_cnt) : '0;
  assign busy       = (r_state == CLEAR);
  assign clear_done = (r_state == DONE);
  assign ReadData1  = w_regs[ReadRegister1];
  assign ReadData2  = w_regs[ReadRegister2];
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      assign w_regs[i] = '0;
    end else begin : g_store
      logic [WIDTH-1:0] r_q;
      // storage cell: cleared by the engine or loaded by its decoded write enable
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= '0;
        else if (w_cen[i]) r_q <= '0;
        else if (w_wen[i]) r_q <= WriteData;
      end
      assign w_regs[i] = r_q;
    end
  end
  // clear engine state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
  // clear engine next state: walk registers 0..LAST, then pulse done for one cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: if (clear_req) begin
        w_state_nxt = CLEAR;
        w_cnt_nxt   = '0;
      end
      CLEAR: begin
        w_state_nxt = (r_cnt == LAST) ? DONE : CLEAR;
        w_cnt_nxt   = (r_cnt == LAST) ? r_cnt : r_cnt + 5'd1;
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_regfile_32x64.sv
`timescale 1ns/1ps
// tb_regfile_32x64: vector table, random traffic against an array model, and clear/reset sequences
module tb_regfile_32x64;
  logic        clk = 0, rst_n = 0, RegWrite = 0, clear_req = 0;
  logic [4:0]  WriteRegister = 0, ReadRegister1 = 0, ReadRegister2 = 0;
  logic [63:0] WriteData = 0, ReadData1, ReadData2;
  logic        busy, clear_done;
  int checks = 0, failures = 0;
  logic [63:0] m [32];
  localparam logic [63:0] K = 64'h0101010101010101;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [4:0]  ra1, ra2;
    logic [63:0] e1, e2;
  } vec_t;
  vec_t vt [6];

  regfile_32x64 dut (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .clear_req(clear_req),
    .busy(busy), .clear_done(clear_done)
  );

  always #2500 clk = ~clk;

  function automatic logic [63:0] rd(input logic [4:0] a);
    return (a == 5'd31) ? 64'd0 : m[a];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    RegWrite = 1; WriteRegister = a; WriteData = d;
    tick();
    RegWrite = 0;
    if (a != 5'd31) m[a] = d;
  endtask

  task automatic read_all(input string nm);
    for (int a = 0; a < 32; a++) begin
      ReadRegister1 = 5'(a); ReadRegister2 = 5'(31 - a);
      #1;
      chk({nm, "_rd1"}, ReadData1, rd(5'(a)));
      chk({nm, "_rd2"}, ReadData2, rd(5'(31 - a)));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m[i] = '0;
    vt[0] = '{1'b1, 5'd31, 64'hFFFFFFFFFFFFFFFF, 5'd31, 5'd30, 64'd0, 64'h1E1E1E1E1E1E1E1E};
    vt[1] = '{1'b0, 5'd0,  64'd0,                5'd0,  5'd1,  64'd0, 64'h0101010101010101};
    vt[2] = '{1'b1, 5'd3,  64'h00000000DEADBEEF, 5'd3,  5'd4,  64'h00000000DEADBEEF, 64'h0404040404040404};
    vt[3] = '{1'b0, 5'd0,  64'd0,                5'd15, 5'd16, 64'h0F0F0F0F0F0F0F0F, 64'h1010101010101010};
    vt[4] = '{1'b1, 5'd0,  64'hCAFEF00DCAFEF00D, 5'd0,  5'd31, 64'hCAFEF00DCAFEF00D, 64'd0};
    vt[5] = '{1'b1, 5'd31, 64'h1234,             5'd30, 5'd31, 64'h1E1E1E1E1E1E1E1E, 64'd0};

    #100;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(clear_done), 64'd0);
    read_all("reset");
    @(negedge clk); rst_n = 1;
    tick();

    for (int i = 0; i < 31; i++) wr(5'(i), K * 64'(i));
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i); ReadRegister2 = 5'(31 - i);
      #1;
      chk("fill_rd1", ReadData1, (i == 31) ? 64'd0 : K * 64'(i));
      chk("fill_rd2", ReadData2, (i == 0) ? 64'd0 : K * 64'(31 - i));
    end

    foreach (vt[v]) begin
      RegWrite = vt[v].we; WriteRegister = vt[v].wa; WriteData = vt[v].wd;
      ReadRegister1 = vt[v].ra1; ReadRegister2 = vt[v].ra2;
      tick();
      RegWrite = 0;
      if (vt[v].we && vt[v].wa != 5'd31) m[vt[v].wa] = vt[v].wd;
      chk($sformatf("vec%0d_rd1", v), ReadData1, vt[v].e1);
      chk($sformatf("vec%0d_rd2", v), ReadData2, vt[v].e2);
    end

    ReadRegister1 = 5; RegWrite = 1; WriteRegister = 5; WriteData = 64'hA5;
    #1;
    chk("nobypass_old", ReadData1, K * 64'd5);
    tick();
    RegWrite = 0; m[5] = 64'hA5;
    chk("nobypass_new", ReadData1, 64'hA5);

    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [4:0]  wa;
      logic [63:0] wd;
      we = 1'($urandom); wa = 5'($urandom); wd = {$urandom, $urandom};
      RegWrite = we; WriteRegister = wa; WriteData = wd;
      ReadRegister1 = 5'($urandom); ReadRegister2 = (n % 4 == 0) ? wa : 5'($urandom);
      #1;
      chk("rand_rd1", ReadData1, rd(ReadRegister1));
      chk("rand_rd2", ReadData2, rd(ReadRegister2));
      tick();
      RegWrite = 0;
      if (we && wa != 5'd31) m[wa] = wd;
    end
    read_all("rand_final");

    for (int i = 0; i < 31; i++) wr(5'(i), {$urandom, $urandom} | 64'd1);
    clear_req = 1; RegWrite = 1; WriteRegister = 2; WriteData = 64'h77;
    #1;
    chk("clr_busy_idle", 64'(busy), 64'd0);
    tick();
    clear_req = 0; RegWrite = 0;
    for (int c = 0; c < 31; c++) begin
      ReadRegister1 = 5'(c); ReadRegister2 = (c == 0) ? 5'd30 : 5'(c - 1);
      RegWrite = (c == 10); WriteRegister = 7; WriteData = 64'h1234;
      clear_req = (c == 5);
      #1;
      chk("clr_busy", 64'(busy), 64'd1);
      chk("clr_done_early", 64'(clear_done), 64'd0);
      chk("clr_rd1", ReadData1, rd(ReadRegister1));
      chk("clr_rd2", ReadData2, rd(ReadRegister2));
      tick();
      RegWrite = 0; clear_req = 0;
      m[c] = '0;
    end
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_pulse", 64'(clear_done), 64'd1);
    tick();
    chk("done_once", 64'(clear_done), 64'd0);
    tick();
    chk("no_requeue", 64'(busy), 64'd0);
    read_all("cleared");

    for (int i = 0; i < 31; i++) wr(5'(i), {$urandom, $urandom} | 64'd1);
    clear_req = 1;
    tick();
    clear_req = 0;
    for (int c = 0; c < 10; c++) tick();
    chk("midclr_busy", 64'(busy), 64'd1);
    rst_n = 0;
    #1;
    for (int i = 0; i < 32; i++) m[i] = '0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(clear_done), 64'd0);
    read_all("midrst");
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_hold_done", 64'(clear_done), 64'd0);
    end
    rst_n = 1;
    tick();
    wr(9, 64'h5555AAAA5555AAAA);
    ReadRegister1 = 9; ReadRegister2 = 10;
    #1;
    chk("post_rst_rd1", ReadData1, 64'h5555AAAA5555AAAA);
    chk("post_rst_rd2", ReadData2, 64'd0);
    for (int c = 0; c < 35; c++) begin
      tick();
      chk("post_rst_no_done", 64'(clear_done | busy), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
